// File: rtl/os_result_drain_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// os_result_drain_if : row-stream bus carrying drained result rows | rev 1.0
// ---------------------------------------------------------------------------
interface os_result_drain_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int OUT_WIDTH = 16
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*OUT_WIDTH-1:0] out_data;
  logic [RW-1:0]             out_row;
  logic                      out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_row,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_row,
    input  out_last
  );
endinterface
`default_nettype wire

// File: rtl/os_result_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// os_result_drain : snapshots an output-stationary PE array and streams it out
// row by row. OS_DRAIN_SAT_EN selects saturation instead of truncation. | rev 1.0
// ---------------------------------------------------------------------------
module os_result_drain #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          load_en,
  input  wire logic [ROWS*COLS*ACC_WIDTH-1:0] shadow_in,
  output logic                               busy,
  output logic                               overrun,
  input  wire logic                          overrun_clr,
  os_result_drain_if.master                  drain
);
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROW_W  = COLS * OUT_WIDTH;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                       state_q;
  state_t                       state_d;
  logic [RW-1:0]                row_q;
  logic [ROW_W-1:0]             buf_q [ROWS];
  logic [ROWS*COLS*OUT_WIDTH-1:0] conv;
  logic                         valid;
  logic                         xfer;
  logic                         is_last;

  // Narrowing is applied on the way into the buffer so only OUT_WIDTH bits are stored.
  generate
    for (genvar e = 0; e < ROWS*COLS; e++) begin : g_elem
      if (OUT_WIDTH < ACC_WIDTH) begin : g_narrow
`ifdef OS_DRAIN_SAT_EN
        assign conv[e*OUT_WIDTH +: OUT_WIDTH] =
          (|shadow_in[e*ACC_WIDTH+OUT_WIDTH +: ACC_WIDTH-OUT_WIDTH]) ?
          {OUT_WIDTH{1'b1}} : shadow_in[e*ACC_WIDTH +: OUT_WIDTH];
`else
        logic unused_hi;
        assign unused_hi = ^shadow_in[e*ACC_WIDTH+OUT_WIDTH +: ACC_WIDTH-OUT_WIDTH];
        assign conv[e*OUT_WIDTH +: OUT_WIDTH] = shadow_in[e*ACC_WIDTH +: OUT_WIDTH];
`endif
      end else begin : g_same
        assign conv[e*OUT_WIDTH +: OUT_WIDTH] = shadow_in[e*ACC_WIDTH +: OUT_WIDTH];
      end
    end
  endgenerate

  assign busy    = (state_q != IDLE);
  assign valid   = (state_q == DRAIN);
  assign is_last = (row_q == LAST_ROW);
  assign xfer    = valid & drain.out_ready;

  assign drain.out_valid = valid;
  assign drain.out_row   = row_q;
  assign drain.out_last  = valid & is_last;
  assign drain.out_data  = valid ? buf_q[row_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_en) state_d = CAPTURE;
      CAPTURE: state_d = DRAIN;
      DRAIN:   if (xfer && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Overrun set takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      overrun <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        row_q <= '0;
      end else if (xfer) begin
        row_q <= is_last ? '0 : row_q + 1'b1;
      end
      if (load_en && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Shadow registers settle on the load_en edge, so the snapshot is taken one cycle later.
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) begin
      for (int r = 0; r < ROWS; r++) begin
        buf_q[r] <= conv[r*ROW_W +: ROW_W];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_os_result_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_os_result_drain : directed bench for os_result_drain (4x4, 24 -> 16 bits)
// rev 1.0
// ---------------------------------------------------------------------------
module tb_os_result_drain;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ACC_WIDTH = 24;
  localparam int OUT_WIDTH = 16;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          load_en;
  logic                          overrun_clr;
  logic                          busy;
  logic                          overrun;
  logic [ROWS*COLS*ACC_WIDTH-1:0] shadow_in;
  int                            vectors = 0;
  int                            miscompares = 0;
  logic [63:0]                   exp_conv;

  os_result_drain_if #(.ROWS(ROWS), .COLS(COLS), .OUT_WIDTH(OUT_WIDTH)) dif ();

  os_result_drain #(
    .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .shadow_in  (shadow_in),
    .busy       (busy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .drain      (dif.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element (r,c) = base + r*16 + c
  task automatic set_tile(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        shadow_in[(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH] = 24'(base + r*16 + c);
  endtask

  function automatic logic [63:0] exp_row(input int base, input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*16 +: 16] = 16'(base + r*16 + c);
    return v;
  endfunction

  task automatic check_row(input string tag, input int base, input int r);
    chk($sformatf("%s_valid_r%0d", tag, r), 64'(dif.out_valid), 64'd1);
    chk($sformatf("%s_data_r%0d", tag, r), dif.out_data, exp_row(base, r));
    chk($sformatf("%s_row_r%0d", tag, r), 64'(dif.out_row), 64'(r));
    chk($sformatf("%s_last_r%0d", tag, r), 64'(dif.out_last), (r == ROWS-1) ? 64'd1 : 64'd0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; overrun_clr = 1'b0; dif.out_ready = 1'b1;
    shadow_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_data", dif.out_data, 64'd0);
    chk("rst_row", 64'(dif.out_row), 64'd0);
    chk("rst_last", 64'(dif.out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // Basic tile; shadow only becomes valid after the load_en edge
    shadow_in = {16{24'hA5A5A5}};
    load_en = 1'b1; step(); load_en = 1'b0;
    set_tile(0);
    chk("t1_cap_valid", 64'(dif.out_valid), 64'd0);
    chk("t1_cap_busy", 64'(busy), 64'd1);
    chk("t1_cap_data", dif.out_data, 64'd0);
    step();
    for (int r = 0; r < ROWS; r++) begin
      check_row("t1", 0, r);
      if (r == 2) chk("t1_r2c3", 64'(dif.out_data[63:48]), 64'h23);
      step();
    end
    chk("t1_end_valid", 64'(dif.out_valid), 64'd0);
    chk("t1_end_busy", 64'(busy), 64'd0);
    chk("t1_end_data", dif.out_data, 64'd0);
    chk("t1_end_overrun", 64'(overrun), 64'd0);

    // Backpressure on row 1
    load_en = 1'b1; step(); load_en = 1'b0;
    step();
    check_row("t2", 0, 0); step();
    dif.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_row("t2_stall", 0, 1); step();
    end
    dif.out_ready = 1'b1;
    check_row("t2", 0, 1); step();
    check_row("t2", 0, 2); step();
    check_row("t2", 0, 3); step();
    chk("t2_end_valid", 64'(dif.out_valid), 64'd0);

    // Overrun mid-drain must not disturb the buffered tile
    load_en = 1'b1; step(); load_en = 1'b0;
    set_tile(16'h200);
    step();
    check_row("t3", 16'h200, 0); step();
    load_en = 1'b1; set_tile(16'h500);
    check_row("t3", 16'h200, 1); step();
    load_en = 1'b0;
    chk("t3_ovr_set", 64'(overrun), 64'd1);
    check_row("t3", 16'h200, 2); step();
    check_row("t3", 16'h200, 3); step();
    chk("t3_idle_busy", 64'(busy), 64'd0);
    step(); step();
    chk("t3_ovr_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("t3_ovr_clr", 64'(overrun), 64'd0);

    // Set beats clear; load_en on the final transfer is an overrun, not a new tile
    load_en = 1'b1; step(); load_en = 1'b0;
    set_tile(16'h600);
    load_en = 1'b1; overrun_clr = 1'b1; step();
    load_en = 1'b0; overrun_clr = 1'b0;
    chk("t4_set_wins", 64'(overrun), 64'd1);
    set_tile(16'h900);
    check_row("t4", 16'h600, 0); step();
    overrun_clr = 1'b1;
    check_row("t4", 16'h600, 1); step();
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", 64'(overrun), 64'd0);
    check_row("t4", 16'h600, 2); step();
    load_en = 1'b1;
    check_row("t4", 16'h600, 3); step();
    load_en = 1'b0;
    chk("t4_last_valid", 64'(dif.out_valid), 64'd0);
    chk("t4_last_busy", 64'(busy), 64'd0);
    chk("t4_last_ovr", 64'(overrun), 64'd1);
    step();
    chk("t4_no_capture", 64'(busy), 64'd0);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;

    // Width reduction
    shadow_in = {16{24'h5A5A5A}};
    load_en = 1'b1; step(); load_en = 1'b0;
    shadow_in = '0;
    shadow_in[0  +: 24] = 24'h012345;
    shadow_in[24 +: 24] = 24'h00ABCD;
    shadow_in[48 +: 24] = 24'hFFFFFF;
    shadow_in[72 +: 24] = 24'h010000;
    step();
`ifdef OS_DRAIN_SAT_EN
    exp_conv = {16'hFFFF, 16'hFFFF, 16'hABCD, 16'hFFFF};
`else
    exp_conv = {16'h0000, 16'hFFFF, 16'hABCD, 16'h2345};
`endif
    chk("t5_conv_row0", dif.out_data, exp_conv);
    step();
    chk("t5_conv_row1", dif.out_data, 64'd0);
    step(); step(); step();
    chk("t5_end_busy", 64'(busy), 64'd0);

    // Reset mid-drain aborts the tile
    load_en = 1'b1; step(); load_en = 1'b0;
    set_tile(16'h700);
    step();
    check_row("t6", 16'h700, 0); step();
    rst = 1'b1;
    check_row("t6", 16'h700, 1); step();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(dif.out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_data", dif.out_data, 64'd0);
    chk("t6_rst_last", 64'(dif.out_last), 64'd0);
    chk("t6_rst_row", 64'(dif.out_row), 64'd0);
    step(); step();
    chk("t6_stay_idle", 64'(dif.out_valid), 64'd0);
    load_en = 1'b1; step(); load_en = 1'b0;
    set_tile(16'h800);
    step();
    for (int r = 0; r < ROWS; r++) begin
      check_row("t6_fresh", 16'h800, r); step();
    end
    chk("t6_end_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
